// File: rtl/ppu_lcd_timing.sv
// PPU LCD timing generator: dot/line counters, STAT mode sequence,
// LY=LYC coincidence and V-Blank / STAT interrupt request pulses.
module ppu_lcd_timing #(
    parameter int DOTS_PER_LINE   = 456,
    parameter int VISIBLE_LINES   = 144,
    parameter int TOTAL_LINES     = 154,
    parameter int OAM_SCAN_DOTS   = 80,
    parameter int MODE3_BASE_DOTS = 172,
    parameter int X_WIDTH         = 9,
    parameter int Y_WIDTH         = 8
) (
    input  logic               clk4_2,
    input  logic               reset_n,
    input  logic               lcd_en,
    input  logic [3:0]         stat_sel,
    input  logic [Y_WIDTH-1:0] lyc,
    input  logic [7:0]         mode3_extra,
    output logic [X_WIDTH-1:0] counterX,
    output logic [Y_WIDTH-1:0] counterY,
    output logic [1:0]         stat_mode,
    output logic               lyc_match,
    output logic               line_start,
    output logic               v_blank_int_sig,
    output logic               stat_int_sig
);

    localparam logic [1:0] MODE_HBLANK = 2'b00;
    localparam logic [1:0] MODE_VBLANK = 2'b01;
    localparam logic [1:0] MODE_OAM    = 2'b10;
    localparam logic [1:0] MODE_XFER   = 2'b11;

    localparam int LW = X_WIDTH + 1;

    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(DOTS_PER_LINE - 1);
    localparam logic [X_WIDTH-1:0] X_OAM  = X_WIDTH'(OAM_SCAN_DOTS);
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(TOTAL_LINES - 1);
    localparam logic [Y_WIDTH-1:0] Y_VIS  = Y_WIDTH'(VISIBLE_LINES);

    localparam logic [LW-1:0] OAM_W    = LW'(OAM_SCAN_DOTS);
    localparam logic [LW-1:0] LEN_BASE = LW'(MODE3_BASE_DOTS);
    localparam logic [LW-1:0] LEN_MAX  =
        LW'(DOTS_PER_LINE - OAM_SCAN_DOTS - 1);

    logic               running;
    logic [LW-1:0]      len_q;
    logic [LW-1:0]      len_req;
    logic [LW-1:0]      len_cap;
    logic [LW-1:0]      len_eff;
    logic [LW-1:0]      xfer_end;
    logic               load_len;
    logic [X_WIDTH-1:0] x_next;
    logic [Y_WIDTH-1:0] y_next;
    logic [1:0]         mode_next;
    logic               stat_line;
    logic               stat_line_q;

    // After idle or reset the first enabled edge presents dot (0,0).
    always_comb begin
        x_next = '0;
        y_next = '0;
        if (running) begin
            if (counterX == X_LAST) begin
                x_next = '0;
                if (counterY == Y_LAST) begin
                    y_next = '0;
                end else begin
                    y_next = counterY + 1'b1;
                end
            end else begin
                x_next = counterX + 1'b1;
                y_next = counterY;
            end
        end
    end

    // Clamp keeps at least one HBlank dot at the end of every line.
    always_comb begin
        len_req  = LEN_BASE + LW'(mode3_extra);
        len_cap  = (len_req > LEN_MAX) ? LEN_MAX : len_req;
        load_len = (x_next == X_OAM) && (y_next < Y_VIS);
        len_eff  = load_len ? len_cap : len_q;
        xfer_end = OAM_W + len_eff;
    end

    always_comb begin
        mode_next = MODE_HBLANK;
        if (y_next >= Y_VIS) begin
            mode_next = MODE_VBLANK;
        end else if (x_next < X_OAM) begin
            mode_next = MODE_OAM;
        end else if ({1'b0, x_next} < xfer_end) begin
            mode_next = MODE_XFER;
        end else begin
            mode_next = MODE_HBLANK;
        end
    end

    always_comb begin
        stat_line = lcd_en & (
            (stat_sel[3] & lyc_match) |
            (stat_sel[2] & (stat_mode == MODE_OAM)) |
            (stat_sel[1] & (stat_mode == MODE_VBLANK)) |
            (stat_sel[0] & (stat_mode == MODE_HBLANK)));
    end

    always_ff @(posedge clk4_2 or negedge reset_n) begin
        if (!reset_n) begin
            running         <= 1'b0;
            counterX        <= '0;
            counterY        <= '0;
            stat_mode       <= MODE_HBLANK;
            lyc_match       <= 1'b0;
            line_start      <= 1'b0;
            v_blank_int_sig <= 1'b0;
            stat_int_sig    <= 1'b0;
            stat_line_q     <= 1'b0;
            len_q           <= LEN_BASE;
        end else if (!lcd_en) begin
            running         <= 1'b0;
            counterX        <= '0;
            counterY        <= '0;
            stat_mode       <= MODE_HBLANK;
            lyc_match       <= (lyc == '0);
            line_start      <= 1'b0;
            v_blank_int_sig <= 1'b0;
            stat_int_sig    <= 1'b0;
            stat_line_q     <= 1'b0;
            len_q           <= LEN_BASE;
        end else begin
            running         <= 1'b1;
            counterX        <= x_next;
            counterY        <= y_next;
            stat_mode       <= mode_next;
            lyc_match       <= (y_next == lyc);
            line_start      <= (x_next == '0);
            v_blank_int_sig <= (x_next == '0) && (y_next == Y_VIS);
            // Rising edge only: overlapping sources keep the line high.
            stat_int_sig    <= stat_line & ~stat_line_q;
            stat_line_q     <= stat_line;
            if (load_len) begin
                len_q <= len_cap;
            end
        end
    end

endmodule

// File: tb/tb_ppu_lcd_timing.sv
// Scoreboard bench for ppu_lcd_timing: full frame, mode 3 lengths,
// STAT sources, LCD disable and asynchronous reset.
module tb_ppu_lcd_timing;

    localparam int DPL   = 456;
    localparam int VIS   = 144;
    localparam int TL    = 154;
    localparam int OAM   = 80;
    localparam int BASE  = 172;
    localparam int LMAX  = DPL - OAM - 1;
    localparam int FRAME = DPL * TL;

    logic       clk4_2 = 1'b0;
    logic       reset_n = 1'b0;
    logic       lcd_en = 1'b0;
    logic [3:0] stat_sel = 4'b0000;
    logic [7:0] lyc = 8'd0;
    logic [7:0] mode3_extra = 8'd0;
    logic [8:0] counterX;
    logic [7:0] counterY;
    logic [1:0] stat_mode;
    logic       lyc_match;
    logic       line_start;
    logic       v_blank_int_sig;
    logic       stat_int_sig;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [8:0] x;
        logic [7:0] y;
        logic [1:0] mode;
        logic       lm;
        logic       ls;
        logic       vb;
        logic       si;
    } exp_t;

    exp_t sb[$];

    ppu_lcd_timing dut (
        .clk4_2          (clk4_2),
        .reset_n         (reset_n),
        .lcd_en          (lcd_en),
        .stat_sel        (stat_sel),
        .lyc             (lyc),
        .mode3_extra     (mode3_extra),
        .counterX        (counterX),
        .counterY        (counterY),
        .stat_mode       (stat_mode),
        .lyc_match       (lyc_match),
        .line_start      (line_start),
        .v_blank_int_sig (v_blank_int_sig),
        .stat_int_sig    (stat_int_sig)
    );

    always #5 clk4_2 = ~clk4_2;

    task automatic tick();
        @(posedge clk4_2);
        #1;
    endtask

    function automatic logic [1:0] exp_mode(int x, int y, int len);
        if (y >= VIS) return 2'b01;
        if (x < OAM) return 2'b10;
        if (x < OAM + len) return 2'b11;
        return 2'b00;
    endfunction

    function automatic int line_extra(int y);
        case (y % 4)
            0: return 0;
            1: return 12;
            2: return 255;
            default: return y;
        endcase
    endfunction

    function automatic int clamp_len(int e);
        return (BASE + e > LMAX) ? LMAX : BASE + e;
    endfunction

    function automatic logic stat_fn(logic [3:0] s, logic [1:0] m, logic lm);
        return (s[3] & lm) | (s[2] & (m == 2'b10)) |
               (s[1] & (m == 2'b01)) | (s[0] & (m == 2'b00));
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        lcd_en = 1'b0;
        lyc = 8'd0;
        tick();
        tick();
        checks += 7;
        if (counterX !== 9'd0) begin
            errors++; $display("FAIL reset.x got %0d want 0", counterX);
        end
        if (counterY !== 8'd0) begin
            errors++; $display("FAIL reset.y got %0d want 0", counterY);
        end
        if (stat_mode !== 2'b00) begin
            errors++; $display("FAIL reset.mode got %0b want 00", stat_mode);
        end
        if (lyc_match !== 1'b0) begin
            errors++; $display("FAIL reset.lyc_match got %b want 0", lyc_match);
        end
        if (line_start !== 1'b0) begin
            errors++; $display("FAIL reset.line_start got %b want 0", line_start);
        end
        if (v_blank_int_sig !== 1'b0) begin
            errors++; $display("FAIL reset.vblank got %b want 0", v_blank_int_sig);
        end
        if (stat_int_sig !== 1'b0) begin
            errors++; $display("FAIL reset.stat_int got %b want 0", stat_int_sig);
        end
        reset_n = 1'b1;
        tick();
        checks += 2;
        if (lyc_match !== 1'b1) begin
            errors++; $display("FAIL idle.lyc0 got %b want 1", lyc_match);
        end
        if (stat_mode !== 2'b00) begin
            errors++; $display("FAIL idle.mode got %0b want 00", stat_mode);
        end
        lyc = 8'd5;
        tick();
        checks++;
        if (lyc_match !== 1'b0) begin
            errors++; $display("FAIL idle.lyc5 got %b want 0", lyc_match);
        end
    endtask

    task automatic test_frame();
        int vb_cnt = 0;
        int lyc_pulses = 0;
        int lyc_pulse_t = -1;
        int oam_pulses = 0;
        int start_pulses = 0;
        int hb_pulses = 0;
        int wr_pulses = 0;
        int vbl_pulses = 0;
        int hb2 = 0;
        int len = BASE;
        logic [1:0] pm = 2'b00;
        logic plm = 1'b0;
        logic slq = 1'b0;
        exp_t e;
        exp_t g;
        logic sl;
        lcd_en = 1'b1;
        for (int t = 0; t <= FRAME; t++) begin
            int x;
            int y;
            x = t % DPL;
            y = (t / DPL) % TL;
            if (y < 10) begin
                stat_sel = 4'b1000; lyc = 8'd5;
            end else if (y < 20) begin
                stat_sel = 4'b0100; lyc = 8'd200;
            end else if (y < 30) begin
                stat_sel = 4'b0101; lyc = 8'd200;
            end else begin
                stat_sel = 4'b1010;
                lyc = (y == 40 && x >= 300) ? 8'd40 : 8'd150;
            end
            if (x == OAM && y < VIS) begin
                mode3_extra = 8'(line_extra(y));
                len = clamp_len(line_extra(y));
            end else begin
                mode3_extra = 8'($urandom_range(0, 255));
            end
            e.x = 9'(x);
            e.y = 8'(y);
            e.mode = exp_mode(x, y, len);
            e.lm = (y == int'(lyc));
            e.ls = (x == 0);
            e.vb = (x == 0 && y == VIS);
            sl = stat_fn(stat_sel, pm, plm);
            e.si = sl & ~slq;
            slq = sl;
            pm = e.mode;
            plm = e.lm;
            sb.push_back(e);
            tick();
            g = sb.pop_front();
            checks += 7;
            if (counterX !== g.x) begin
                errors++; $display("FAIL frame.x t=%0d got %0d want %0d", t, counterX, g.x);
            end
            if (counterY !== g.y) begin
                errors++; $display("FAIL frame.y t=%0d got %0d want %0d", t, counterY, g.y);
            end
            if (stat_mode !== g.mode) begin
                errors++; $display("FAIL frame.mode t=%0d got %0b want %0b", t, stat_mode, g.mode);
            end
            if (lyc_match !== g.lm) begin
                errors++; $display("FAIL frame.lyc_match t=%0d got %b want %b", t, lyc_match, g.lm);
            end
            if (line_start !== g.ls) begin
                errors++; $display("FAIL frame.line_start t=%0d got %b want %b", t, line_start, g.ls);
            end
            if (v_blank_int_sig !== g.vb) begin
                errors++; $display("FAIL frame.vblank t=%0d got %b want %b", t, v_blank_int_sig, g.vb);
            end
            if (stat_int_sig !== g.si) begin
                errors++; $display("FAIL frame.stat_int t=%0d got %b want %b", t, stat_int_sig, g.si);
            end
            if (t > 0 && v_blank_int_sig === 1'b1) vb_cnt++;
            if (y < 10 && stat_int_sig === 1'b1) begin
                lyc_pulses++;
                lyc_pulse_t = t;
            end
            if (y >= 10 && y < 20 && stat_int_sig === 1'b1 && x == 1) oam_pulses++;
            if (y >= 21 && y < 30 && stat_int_sig === 1'b1) begin
                hb_pulses++;
                if (x == 1) start_pulses++;
            end
            if (y == 40 && stat_int_sig === 1'b1) wr_pulses++;
            if (y >= 145 && t < FRAME && stat_int_sig === 1'b1) vbl_pulses++;
            if (y == 2 && stat_mode === 2'b00) hb2++;
        end
        checks += 8;
        if (vb_cnt != 1) begin
            errors++; $display("FAIL frame.vblank_count got %0d want 1", vb_cnt);
        end
        if (lyc_pulses != 1 || lyc_pulse_t != 5 * DPL + 1) begin
            errors++;
            $display("FAIL frame.lyc_pulse got %0d at t=%0d want 1 at t=%0d",
                     lyc_pulses, lyc_pulse_t, 5 * DPL + 1);
        end
        if (oam_pulses != 10) begin
            errors++; $display("FAIL frame.oam_pulses got %0d want 10", oam_pulses);
        end
        if (start_pulses != 0) begin
            errors++; $display("FAIL frame.blocked_start got %0d want 0", start_pulses);
        end
        if (hb_pulses != 9) begin
            errors++; $display("FAIL frame.hblank_pulses got %0d want 9", hb_pulses);
        end
        if (wr_pulses != 1) begin
            errors++; $display("FAIL frame.lyc_write got %0d want 1", wr_pulses);
        end
        if (vbl_pulses != 0) begin
            errors++; $display("FAIL frame.vblank_blocking got %0d want 0", vbl_pulses);
        end
        if (hb2 != 1) begin
            errors++; $display("FAIL frame.clamp_hblank got %0d want 1", hb2);
        end
    endtask

    task automatic test_lcd_disable();
        int pulses = 0;
        logic [1:0] pm = 2'b00;
        logic plm;
        logic slq = 1'b0;
        logic sl;
        exp_t e;
        exp_t g;
        stat_sel = 4'b0000;
        lyc = 8'd200;
        mode3_extra = 8'd0;
        for (int i = 0; i < 3 * DPL + 200; i++) tick();
        checks += 3;
        if (counterX !== 9'd200 || counterY !== 8'd3) begin
            errors++; $display("FAIL dis.pos got (%0d,%0d) want (200,3)", counterX, counterY);
        end
        if (stat_mode !== 2'b11) begin
            errors++; $display("FAIL dis.pre_mode got %0b want 11", stat_mode);
        end
        lcd_en = 1'b0;
        stat_sel = 4'b1111;
        lyc = 8'd0;
        tick();
        if (counterX !== 9'd0 || counterY !== 8'd0) begin
            errors++; $display("FAIL dis.zero got (%0d,%0d) want (0,0)", counterX, counterY);
        end
        for (int i = 0; i < 4; i++) begin
            checks += 3;
            if (stat_mode !== 2'b00) begin
                errors++; $display("FAIL dis.mode got %0b want 00", stat_mode);
            end
            if ({line_start, v_blank_int_sig, stat_int_sig} !== 3'b000) begin
                errors++;
                $display("FAIL dis.pulses got %b%b%b want 000",
                         line_start, v_blank_int_sig, stat_int_sig);
            end
            if (lyc_match !== 1'b1) begin
                errors++; $display("FAIL dis.lyc_match got %b want 1", lyc_match);
            end
            tick();
        end
        plm = 1'b1;
        lcd_en = 1'b1;
        stat_sel = 4'b0100;
        lyc = 8'd200;
        for (int t = 0; t <= 2 * DPL; t++) begin
            e.x = 9'(t % DPL);
            e.y = 8'(t / DPL);
            e.mode = exp_mode(t % DPL, t / DPL, BASE);
            e.lm = 1'b0;
            e.ls = (t % DPL == 0);
            e.vb = 1'b0;
            sl = stat_fn(stat_sel, pm, plm);
            e.si = sl & ~slq;
            slq = sl;
            pm = e.mode;
            plm = e.lm;
            sb.push_back(e);
            tick();
            g = sb.pop_front();
            checks += 4;
            if (counterX !== g.x || counterY !== g.y) begin
                errors++;
                $display("FAIL reen.pos t=%0d got (%0d,%0d) want (%0d,%0d)",
                         t, counterX, counterY, g.x, g.y);
            end
            if (stat_mode !== g.mode) begin
                errors++; $display("FAIL reen.mode t=%0d got %0b want %0b", t, stat_mode, g.mode);
            end
            if (stat_int_sig !== g.si) begin
                errors++; $display("FAIL reen.stat_int t=%0d got %b want %b", t, stat_int_sig, g.si);
            end
            if (line_start !== g.ls) begin
                errors++; $display("FAIL reen.line_start t=%0d got %b want %b", t, line_start, g.ls);
            end
            if (stat_int_sig === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 2) begin
            errors++; $display("FAIL reen.pulse_count got %0d want 2", pulses);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 100; i++) tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks += 3;
        if (counterX !== 9'd0 || counterY !== 8'd0 || stat_mode !== 2'b00) begin
            errors++;
            $display("FAIL arst.state got (%0d,%0d,%0b) want (0,0,00)",
                     counterX, counterY, stat_mode);
        end
        if ({lyc_match, line_start, v_blank_int_sig, stat_int_sig} !== 4'b0000) begin
            errors++;
            $display("FAIL arst.flags got %b%b%b%b want 0000",
                     lyc_match, line_start, v_blank_int_sig, stat_int_sig);
        end
        tick();
        if (counterX !== 9'd0) begin
            errors++; $display("FAIL arst.hold got %0d want 0", counterX);
        end
        reset_n = 1'b1;
        tick();
        checks += 3;
        if (counterX !== 9'd0 || counterY !== 8'd0) begin
            errors++; $display("FAIL arst.resume got (%0d,%0d) want (0,0)", counterX, counterY);
        end
        if (stat_mode !== 2'b10 || line_start !== 1'b1) begin
            errors++;
            $display("FAIL arst.resume_mode got %0b/%b want 10/1", stat_mode, line_start);
        end
        tick();
        if (counterX !== 9'd1 || stat_int_sig !== 1'b1) begin
            errors++;
            $display("FAIL arst.oam_int got x=%0d int=%b want x=1 int=1",
                     counterX, stat_int_sig);
        end
        for (int i = 0; i < 79; i++) tick();
        checks++;
        if (counterX !== 9'd80 || stat_mode !== 2'b11) begin
            errors++;
            $display("FAIL arst.xfer got x=%0d mode=%0b want x=80 mode=11",
                     counterX, stat_mode);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_lcd_disable();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
